// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder
//   Drives N_DIGITS time-multiplexed 7-segment digits from one shared segment
//   bus. Digit values are written through a valid/ready port into a shadow
//   buffer. The shadow buffer is copied to the display buffer only at a frame
//   wrap, so one frame never shows a mix of old and new values.
//
// Ports
//   clock       rising-edge clock
//   reset       synchronous, active-high reset
//   wr_valid    write request
//   wr_ready    write can be accepted this cycle (low in the commit cycle)
//   wr_addr     target digit index (N_DIGITS-1 is most significant)
//   wr_data     digit value 0x0..0xF
//   mode        0 hex, 1 BCD (values >9 blank), 2 hex with leading-zero blanking, 3 off
//   seg         segments {g,f,e,d,c,b,a}
//   dig_en      one-hot digit enable
//   frame_tick  one-cycle pulse in the cycle after each frame wrap
module seg7_scan_decoder #(
  parameter int N_DIGITS   = 4,
  parameter int PRESCALE   = 1024,
  parameter int ACTIVE_LOW = 0,
  localparam int AW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [AW-1:0]       wr_addr,
  input  logic [3:0]          wr_data,
  input  logic [1:0]          mode,
  output logic [6:0]          seg,
  output logic [N_DIGITS-1:0] dig_en,
  output logic                frame_tick
);

  localparam int PW = $clog2(PRESCALE);

  localparam logic [PW-1:0]       PRE_LAST   = PW'(PRESCALE - 1);
  localparam logic [PW-1:0]       PRE_PENULT = PW'(PRESCALE - 2);
  localparam logic [PW-1:0]       PRE_ONE    = PW'(1);
  localparam logic [AW-1:0]       IDX_LAST   = AW'(N_DIGITS - 1);
  localparam logic [AW-1:0]       IDX_ONE    = AW'(1);
  localparam logic [6:0]          SEG_POL    = (ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [N_DIGITS-1:0] DIG_POL    = (ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [N_DIGITS-1:0] DIG_ONE    = N_DIGITS'(1);

  // Active-high hex decode, bit 0 = segment a.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] value);
    logic [6:0] pattern;
    case (value)
      4'h0:    pattern = 7'h3F;
      4'h1:    pattern = 7'h06;
      4'h2:    pattern = 7'h5B;
      4'h3:    pattern = 7'h4F;
      4'h4:    pattern = 7'h66;
      4'h5:    pattern = 7'h6D;
      4'h6:    pattern = 7'h7D;
      4'h7:    pattern = 7'h07;
      4'h8:    pattern = 7'h7F;
      4'h9:    pattern = 7'h6F;
      4'hA:    pattern = 7'h77;
      4'hB:    pattern = 7'h7C;
      4'hC:    pattern = 7'h39;
      4'hD:    pattern = 7'h5E;
      4'hE:    pattern = 7'h79;
      4'hF:    pattern = 7'h71;
      default: pattern = 7'h00;
    endcase
    return pattern;
  endfunction

  logic [PW-1:0]       pre_r;
  logic [AW-1:0]       idx_r;
  logic [3:0]          shadow_r [N_DIGITS];
  logic [3:0]          disp_r   [N_DIGITS];
  logic                dirty_r;
  logic                wr_ready_r;
  logic                frame_tick_r;
  logic [6:0]          seg_r;
  logic [N_DIGITS-1:0] dig_en_r;

  logic                commit_s;
  logic                commit_next_s;
  logic                wr_fire_s;
  logic                addr_ok_s;
  logic [3:0]          cur_val_s;
  logic [6:0]          hex_seg_s;
  logic                zero_run_s;
  logic [N_DIGITS-1:0] lz_mask_s;
  logic [6:0]          seg_next_s;
  logic [N_DIGITS-1:0] dig_next_s;

  assign commit_s      = (pre_r == PRE_LAST) && (idx_r == IDX_LAST);
  // The prescaler only increments, so the commit cycle always follows PRESCALE-2
  // on the last digit; this lets wr_ready drop exactly in the commit cycle.
  assign commit_next_s = (pre_r == PRE_PENULT) && (idx_r == IDX_LAST);
  assign wr_fire_s     = wr_valid && wr_ready_r;
  assign addr_ok_s     = (32'(wr_addr) < N_DIGITS);

  // Leading-zero mask: bit i set when digit i and all more-significant digits are 0.
  always_comb begin
    zero_run_s = 1'b1;
    lz_mask_s  = {N_DIGITS{1'b0}};
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run_s   = zero_run_s && (disp_r[i] == 4'h0);
      lz_mask_s[i] = zero_run_s;
    end
    lz_mask_s[0] = 1'b0;
  end

  // Next segment/enable pattern for the digit currently being scanned.
  always_comb begin
    cur_val_s  = disp_r[idx_r];
    hex_seg_s  = hex_to_seg(cur_val_s);
    seg_next_s = 7'h00;
    dig_next_s = DIG_ONE << idx_r;
    case (mode)
      2'd0: seg_next_s = hex_seg_s;
      2'd1: begin
        if (cur_val_s > 4'd9) begin
          seg_next_s = 7'h00;
        end else begin
          seg_next_s = hex_seg_s;
        end
      end
      2'd2: begin
        if (lz_mask_s[idx_r]) begin
          seg_next_s = 7'h00;
        end else begin
          seg_next_s = hex_seg_s;
        end
      end
      2'd3: begin
        seg_next_s = 7'h00;
        dig_next_s = {N_DIGITS{1'b0}};
      end
      default: begin
        seg_next_s = 7'h00;
        dig_next_s = {N_DIGITS{1'b0}};
      end
    endcase
  end

  // Prescaler and scan index.
  always_ff @(posedge clock) begin
    if (reset) begin
      pre_r <= {PW{1'b0}};
      idx_r <= {AW{1'b0}};
    end else if (pre_r == PRE_LAST) begin
      pre_r <= {PW{1'b0}};
      if (idx_r == IDX_LAST) begin
        idx_r <= {AW{1'b0}};
      end else begin
        idx_r <= idx_r + IDX_ONE;
      end
    end else begin
      pre_r <= pre_r + PRE_ONE;
    end
  end

  // Shadow writes and frame-boundary commit into the display buffer.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < N_DIGITS; i++) begin
        shadow_r[i] <= 4'h0;
        disp_r[i]   <= 4'h0;
      end
      dirty_r <= 1'b0;
    end else if (commit_s) begin
      if (dirty_r) begin
        disp_r  <= shadow_r;
        dirty_r <= 1'b0;
      end
    end else if (wr_fire_s && addr_ok_s) begin
      shadow_r[wr_addr] <= wr_data;
      dirty_r           <= 1'b1;
    end
  end

  // Handshake ready and frame pulse.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ready_r   <= 1'b0;
      frame_tick_r <= 1'b0;
    end else begin
      wr_ready_r   <= !commit_next_s;
      frame_tick_r <= commit_s;
    end
  end

  // Output register with polarity applied last.
  always_ff @(posedge clock) begin
    if (reset) begin
      seg_r    <= SEG_POL;
      dig_en_r <= DIG_POL;
    end else begin
      seg_r    <= seg_next_s ^ SEG_POL;
      dig_en_r <= dig_next_s ^ DIG_POL;
    end
  end

  assign wr_ready   = wr_ready_r;
  assign frame_tick = frame_tick_r;
  assign seg        = seg_r;
  assign dig_en     = dig_en_r;

endmodule
